// File: rtl/prog_encoder.sv
// prog_encoder: packs decoded control vectors into 9-bit instruction words
// {opcode[2:0], operand[5:0]} and writes them to instruction memory at
// consecutive addresses starting from BASE.
// Optional feature macro: PROG_ENC_HALT_APPEND_EN. When it is defined, an
// unconditional branch-to-self (9'b110_000000) is appended after the last word.
module prog_encoder #(
   parameter int AW   = 8,
   parameter int BASE = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [2:0]    alu_op,
   input  logic          reg_write,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          branch,
   input  logic          branch_conditional,
   input  logic [5:0]    operand,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [8:0]    im_wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code,
   output logic [AW:0]   count
);

`ifdef PROG_ENC_HALT_APPEND_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HALT, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

   localparam logic [8:0] HALT_WORD = 9'b110_000000;

   state_t        r_state;
   logic [AW-1:0] r_addr;      // next address to be written
   logic [AW:0]   r_count;
   logic          r_we;
   logic [AW-1:0] r_im_addr;
   logic [8:0]    r_im_wdata;
   logic          r_done;
   logic          r_err;
   logic [1:0]    r_err_code;
   logic [1:0]    r_code;      // error cause latched on entry to ERR

   logic [2:0]    w_opcode;
   logic          w_legal;
   logic          w_at_top;

   // Encode the control vector; anything outside the listed combinations is illegal
   always_comb begin
      w_opcode = 3'b000;
      w_legal  = 1'b0;
      if (alu_op > 3'd3) begin
         w_legal = 1'b0;
      end else if (reg_write && !mem_read && !mem_write && !branch && !branch_conditional) begin
         w_opcode = {1'b0, alu_op[1:0]};
         w_legal  = 1'b1;
      end else if (reg_write && mem_read && !mem_write && !branch && !branch_conditional) begin
         w_opcode = 3'b100;
         w_legal  = 1'b1;
      end else if (!reg_write && !mem_read && mem_write && !branch && !branch_conditional) begin
         w_opcode = 3'b101;
         w_legal  = 1'b1;
      end else if (!reg_write && !mem_read && !mem_write && branch) begin
         w_opcode = {2'b11, branch_conditional};
         w_legal  = 1'b1;
      end
   end

   assign w_at_top = (r_addr == {AW{1'b1}});

   // Load FSM: handshake, memory write port, status flags and word counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_addr     <= AW'(BASE);
         r_count    <= '0;
         r_we       <= 1'b0;
         r_im_addr  <= '0;
         r_im_wdata <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
         r_code     <= 2'b00;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               // Status flags rise one cycle after the terminating strobe
               if (r_state == S_DONE) r_done <= 1'b1;
               if (r_state == S_ERR) begin
                  r_err      <= 1'b1;
                  r_err_code <= r_code;
               end
               if (start) begin
                  r_state    <= S_LOAD;
                  r_addr     <= AW'(BASE);
                  r_count    <= '0;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_err_code <= 2'b00;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  if (w_legal) begin
                     r_we       <= 1'b1;
                     r_im_addr  <= r_addr;
                     r_im_wdata <= {w_opcode, operand};
                     r_count    <= r_count + {{AW{1'b0}}, 1'b1};
                     // Address saturates at the top instead of wrapping
                     if (!w_at_top) r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
                     if (in_last) begin
`ifdef PROG_ENC_HALT_APPEND_EN
                        if (w_at_top) begin
                           r_state <= S_ERR;
                           r_code  <= 2'b10;
                        end else begin
                           r_state <= S_HALT;
                        end
`else
                        r_state <= S_DONE;
`endif
                     end else if (w_at_top) begin
                        r_state <= S_ERR;
                        r_code  <= 2'b10;
                     end
                  end else begin
                     // Illegal vector: nothing written, error reported next cycle
                     r_state    <= S_ERR;
                     r_code     <= 2'b01;
                     r_err      <= 1'b1;
                     r_err_code <= 2'b01;
                  end
               end
            end
`ifdef PROG_ENC_HALT_APPEND_EN
            S_HALT: begin
               r_we       <= 1'b1;
               r_im_addr  <= r_addr;
               r_im_wdata <= HALT_WORD;
               r_count    <= r_count + {{AW{1'b0}}, 1'b1};
               if (!w_at_top) r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
               r_state    <= S_DONE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready = (r_state == S_LOAD);
`ifdef PROG_ENC_HALT_APPEND_EN
   assign busy     = (r_state == S_LOAD) || (r_state == S_HALT);
`else
   assign busy     = (r_state == S_LOAD);
`endif
   assign im_we    = r_we;
   assign im_addr  = r_im_addr;
   assign im_wdata = r_im_wdata;
   assign done     = r_done;
   assign err      = r_err;
   assign err_code = r_err_code;
   assign count    = r_count;

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder: a table of encodings plus hand-written
// multi-cycle sequences. Expected writes are queued when a transfer is driven
// and compared when the strobe appears. An AW=2 instance covers overflow.
module tb_prog_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, in_valid, in_last, sel;
   logic [2:0] alu_op;
   logic       rw, mr, mw, br, bc;
   logic [5:0] operand;

   logic       rdy8, we8, busy8, done8, err8;
   logic [7:0] addr8;
   logic [8:0] wd8;
   logic [8:0] cnt8;
   logic [1:0] ec8;

   logic       rdy2, we2, busy2, done2, err2;
   logic [1:0] addr2;
   logic [8:0] wd2;
   logic [2:0] cnt2;
   logic [1:0] ec2;

   prog_encoder #(.AW(8), .BASE(0)) u8 (
      .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
      .in_ready(rdy8), .in_last(in_last), .alu_op(alu_op), .reg_write(rw),
      .mem_read(mr), .mem_write(mw), .branch(br), .branch_conditional(bc),
      .operand(operand), .im_we(we8), .im_addr(addr8), .im_wdata(wd8),
      .busy(busy8), .done(done8), .err(err8), .err_code(ec8), .count(cnt8)
   );

   prog_encoder #(.AW(2), .BASE(0)) u2 (
      .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
      .in_ready(rdy2), .in_last(in_last), .alu_op(alu_op), .reg_write(rw),
      .mem_read(mr), .mem_write(mw), .branch(br), .branch_conditional(bc),
      .operand(operand), .im_we(we2), .im_addr(addr2), .im_wdata(wd2),
      .busy(busy2), .done(done2), .err(err2), .err_code(ec2), .count(cnt2)
   );

   logic       m_ready, m_done, m_err, m_busy;
   logic [1:0] m_code;
   logic [8:0] m_cnt;
   assign m_ready = sel ? rdy2  : rdy8;
   assign m_done  = sel ? done2 : done8;
   assign m_err   = sel ? err2  : err8;
   assign m_busy  = sel ? busy2 : busy8;
   assign m_code  = sel ? ec2   : ec8;
   assign m_cnt   = sel ? {6'b0, cnt2} : cnt8;

   typedef struct {
      int addr;
      int data;
      int cnt;
      int t;
   } wr_t;

   typedef struct {
      string      name;
      logic [2:0] alu;
      logic       rw, mr, mw, br, bc;
      logic [5:0] opnd;
      bit         legal;
      logic [8:0] word;
   } vec_t;

   wr_t  q8[$];
   wr_t  q2[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   exp_addr = 0;
   int   exp_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end else begin
         $display("ok   %s value=0x%0h", name, act);
      end
   endtask

   // Scoreboard: compare each strobe with the oldest queued expectation
   wr_t e8, e2;
   always @(negedge clk) begin
      if (we8) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write8 actual=addr 0x%0h data 0x%0h required=no write", addr8, wd8);
         end else begin
            e8 = q8.pop_front();
            chk("w8_addr", int'(addr8), e8.addr);
            chk("w8_data", int'(wd8), e8.data);
            chk("w8_count", int'(cnt8), e8.cnt);
            chk("w8_cycle", cyc, e8.t);
         end
      end
      if (we2) begin
         if (q2.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write2 actual=addr 0x%0h data 0x%0h required=no write", addr2, wd2);
         end else begin
            e2 = q2.pop_front();
            chk("w2_addr", int'(addr2), e2.addr);
            chk("w2_data", int'(wd2), e2.data);
            chk("w2_count", int'(cnt2), e2.cnt);
            chk("w2_cycle", cyc, e2.t);
         end
      end
   end

   task automatic set_vec(input vec_t v);
      alu_op = v.alu; rw = v.rw; mr = v.mr; mw = v.mw; br = v.br; bc = v.bc;
      operand = v.opnd;
   endtask

   task automatic push(input int data, input int t);
      wr_t e;
      e.addr = exp_addr;
      e.data = data;
      exp_cnt++;
      e.cnt  = exp_cnt;
      e.t    = t;
      if (sel) q2.push_back(e); else q8.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_addr = 0;
      exp_cnt  = 0;
   endtask

   // One handshake transfer; queues the expected write(s) for a legal vector
   task automatic xfer(input vec_t v, input bit last);
      bit got;
      int top;
      bit was_top;
      top = sel ? 3 : 255;
      set_vec(v);
      in_last  = last;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL xfer_timeout %s actual=in_ready low required=in_ready high", v.name);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (v.legal) begin
         was_top = (exp_addr == top);
         push(int'(v.word), cyc);
         if (!was_top) exp_addr++;
`ifdef PROG_ENC_HALT_APPEND_EN
         if (last && !was_top) begin
            push(32'h180, cyc + 1);
            exp_addr++;
         end
`endif
      end
   endtask

   task automatic wait_end(input string name, input bit exp_done, input bit exp_err, input int exp_code);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_done || m_err) begin got = 1'b1; break; end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s_timeout actual=no done/err required=done or err", name);
      end
      chk({name, "_done"}, int'(m_done), int'(exp_done));
      chk({name, "_err"}, int'(m_err), int'(exp_err));
      chk({name, "_err_code"}, int'(m_code), exp_code);
      chk({name, "_count"}, int'(m_cnt), exp_cnt);
      chk({name, "_busy"}, int'(m_busy), 0);
      chk({name, "_in_ready"}, int'(m_ready), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals(input string name);
      @(negedge clk);
      chk({name, "_in_ready"}, int'(rdy8), 0);
      chk({name, "_im_we"}, int'(we8), 0);
      chk({name, "_busy"}, int'(busy8), 0);
      chk({name, "_done"}, int'(done8), 0);
      chk({name, "_err"}, int'(err8), 0);
      chk({name, "_im_addr"}, int'(addr8), 0);
      chk({name, "_im_wdata"}, int'(wd8), 0);
      chk({name, "_err_code"}, int'(ec8), 0);
      chk({name, "_count"}, int'(cnt8), 0);
      @(posedge clk); #1;
   endtask

   vec_t tbl[11];
   vec_t v;

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{"ADD",   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h05, 1'b1, 9'h005};
      tbl[1]  = '{"ALU1",  3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2A, 1'b1, 9'h06A};
      tbl[2]  = '{"ALU3",  3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h11, 1'b1, 9'h0D1};
      tbl[3]  = '{"LDR",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, 1'b1, 9'h13F};
      tbl[4]  = '{"STR",   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h07, 1'b1, 9'h147};
      tbl[5]  = '{"B",     3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 9'h180};
      tbl[6]  = '{"BRZ",   3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h15, 1'b1, 9'h1D5};
      tbl[7]  = '{"ILL_ALU5", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b0, 9'h000};
      tbl[8]  = '{"ILL_BC",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h02, 1'b0, 9'h000};
      tbl[9]  = '{"ILL_MR",   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h03, 1'b0, 9'h000};
      tbl[10] = '{"ILL_RWMW", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h04, 1'b0, 9'h000};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
      alu_op = 3'd0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; bc = 1'b0; operand = 6'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_vals("reset");

      // ADD then LDR marked last
      do_start();
      chk("load_busy", int'(busy8), 1);
      chk("load_in_ready", int'(rdy8), 1);
      xfer(tbl[0], 1'b0);
      xfer(tbl[3], 1'b1);
      wait_end("add_ldr", 1'b1, 1'b0, 0);

      // Streaming: four BRZ words, valid held high, back-to-back strobes
      begin
         int t0;
         do_start();
         t0 = cyc;
         for (int k = 1; k <= 4; k++) begin
            v = tbl[6];
            v.name = "BRZ_STREAM";
            v.opnd = 6'(k);
            v.word = 9'h1C0 + 9'(k);
            xfer(v, k == 4);
         end
         chk("stream_cycles", cyc - t0, 4);
         wait_end("stream", 1'b1, 1'b0, 0);
      end

      // Encoding table: one single-word load per entry
      for (int i = 0; i < 11; i++) begin
         do_start();
         chk({tbl[i].name, "_start_err"}, int'(err8), 0);
         chk({tbl[i].name, "_start_done"}, int'(done8), 0);
         chk({tbl[i].name, "_start_count"}, int'(cnt8), 0);
         xfer(tbl[i], 1'b1);
         wait_end(tbl[i].name, tbl[i].legal, !tbl[i].legal, tbl[i].legal ? 0 : 1);
      end

      // start pulsed mid-load is ignored
      do_start();
      xfer(tbl[0], 1'b0);
      start = 1'b1;
      xfer(tbl[1], 1'b0);
      start = 1'b0;
      chk("midstart_count", int'(cnt8), 2);
      chk("midstart_busy", int'(busy8), 1);
      xfer(tbl[4], 1'b1);
      wait_end("midstart", 1'b1, 1'b0, 0);

      // reset after two of four words, coinciding with the third transfer
      do_start();
      xfer(tbl[0], 1'b0);
      xfer(tbl[1], 1'b0);
      set_vec(tbl[4]);
      in_valid = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      exp_addr = 0;
      exp_cnt  = 0;
      check_reset_vals("midreset");
      do_start();
      xfer(tbl[5], 1'b1);
      wait_end("after_reset", 1'b1, 1'b0, 0);

      // Overflow on the AW=2 instance: fifth word refused
      sel = 1'b1;
      do_start();
      for (int k = 0; k < 4; k++) begin
         v = tbl[0];
         v.name = "OVF";
         v.opnd = 6'(k + 8);
         v.word = 9'(k + 8);
         xfer(v, 1'b0);
      end
      set_vec(tbl[0]);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ovf_fifth_in_ready", int'(m_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_end("overflow", 1'b0, 1'b1, 2);
      sel = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("q8_drained", q8.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
